cam_frame_capture_ctrl: RTL and testbench
=========================================

Name: cam_frame_capture_ctrl

Overview:
Sequences capture of one camera frame from the YUV-to-RGB scan datapath into an 8-bit RGB332 frame buffer. On request it arms, aligns to the next full frame using vsync, and packs each converted pixel pair (r1/g1/b1, r2/g2/b2). It then writes the pair on two consecutive cycles to sequential buffer addresses, tracking pixel and line counts. It reports completion, framing errors and busy status to the host-side logic.

Parameters:
H_PIXELS, 640, pixels per line written to the buffer
V_LINES, 480, lines per frame
ADDR_W, 19, frame buffer address width (H_PIXELS*V_LINES must be <= 2^ADDR_W)
CNT_W, 11, width of pixel and line counters

Ports:
pclk  in  1  camera pixel clock; the only clock
reset_n  in  1  asynchronous active-low reset
capture_req  in  1  level; capture one frame when high in IDLE
continuous  in  1  1 = re-arm automatically after each frame
vsync  in  1  camera vertical sync, high between frames
href  in  1  camera line valid
data_valid  in  1  one-cycle strobe from the RGB datapath; pixel pair valid
r1, g1, b1, r2, g2, b2  in  8 each  converted pixel pair, sampled only when data_valid=1
wr_addr  out  ADDR_W  frame buffer write address
wr_data  out  8  RGB332 pixel {r[7:5], g[7:5], b[7:6]}
wren  out  1  frame buffer write enable
busy  out  1  high in ARMED, SYNC, CAPTURE
frame_done  out  1  one-cycle pulse on frame completion
frame_error  out  1  sticky; cleared on entry to ARMED
line_count  out  CNT_W  lines completed in current frame

Behaviour:
- Reset values: state=IDLE; wr_addr=0, wr_data=0, wren=0, busy=0, frame_done=0, frame_error=0, line_count=0. Edge registers last_vsync=0 and last_href=0; pixel count, line base and pending flag are also 0.
- Reset is asynchronous and may occur mid-frame: wren drops immediately and no further writes occur until the next full arm/sync sequence.
- Edge detection is registered: vsync_rise = vsync & ~last_vsync, vsync_fall = ~vsync & last_vsync, href_fall = ~href & last_href.
- IDLE: capture_req=1 -> ARMED.
- ARMED: clear frame_error on entry. vsync_rise -> SYNC. This never starts mid-frame.
- SYNC: vsync_fall -> CAPTURE, clearing pix_cnt, line_count and line_base to 0.
- CAPTURE, data_valid=1 with pix_cnt < H_PIXELS and line_count < V_LINES:
  - Next cycle: wren=1, wr_data=pack(r1,g1,b1), wr_addr=line_base+pix_cnt.
  - Latch pack(r2,g2,b2) and set pending.
  - Following cycle: wren=1, wr_data=pending pixel, wr_addr=previous+1. Clear pending.
  - pix_cnt += 2. Write latency is 1 cycle from data_valid for pixel 1 and 2 cycles for pixel 2.
- If pix_cnt = H_PIXELS-1, only pixel 1 is written; pixel 2 is dropped and frame_error is set.
- data_valid with pix_cnt >= H_PIXELS: pair dropped, frame_error=1.
- data_valid while pending=1: the pending pixel is still written; the new pair is dropped and frame_error=1.
- href_fall in CAPTURE:
  - if pix_cnt != H_PIXELS, frame_error=1
  - line_count += 1, line_base += H_PIXELS, pix_cnt=0
  - an in-flight pending write completes at its original address
- line_count reaching V_LINES -> DONE. A pending write still completes in the DONE cycle.
- vsync_rise in CAPTURE with line_count < V_LINES: frame_error=1 -> DONE (short frame).
- DONE (one cycle): frame_done=1. Then:
  - continuous=1 -> ARMED
  - else -> IDLE
  - capture_req must be re-asserted (or still high) in IDLE to start again.
- wren is 0 in every cycle without a write. wr_addr/wr_data hold their last value when wren=0.
- href and data_valid are ignored outside CAPTURE. capture_req is ignored outside IDLE.

Test Plan:
- H_PIXELS=4, V_LINES=2, capture_req=1, continuous=0; vsync pulse then 2 lines of 2 data_valid strobes each (4 cycles apart) with r1=0xFF,g1=0,b1=0,r2=0,g2=0xFF,b2=0xC0 -> writes addr 0..7 alternating 0xE0/0x1F, single frame_done pulse, frame_error=0, return to IDLE, busy low.
- data_valid asserted before first vsync_fall after arming -> no wren at all; capture starts only after vsync falls.
- Line with only 1 strobe (2 pixels) then href_fall -> frame_error=1, next line starts at addr 4, frame still completes after 2 lines.
- vsync rises after 1 line -> frame_error=1, frame_done pulses, line_count=1.
- continuous=1, three frames -> three frame_done pulses, wr_addr restarts at 0 each frame, frame_error cleared on each arm.
- reset_n low during CAPTURE on the second-pixel cycle -> wren=0 immediately, all outputs at reset values. After release, no writes until capture_req plus a full vsync rise/fall.

Source files
------------

// File: rtl/cam_frame_capture_ctrl_if.sv
// Camera-side scan inputs, frame buffer write port and host status for the capture controller.
// Latency: none; this only bundles signals.
// Backpressure: none; the write port is fire-and-forget and the buffer must accept every wren.
interface cam_frame_capture_ctrl_if #(
    parameter int ADDR_W = 19,
    parameter int CNT_W  = 11
);
    logic              capture_req;
    logic              continuous;
    logic              vsync;
    logic              href;
    logic              data_valid;
    logic [7:0]        r1;
    logic [7:0]        g1;
    logic [7:0]        b1;
    logic [7:0]        r2;
    logic [7:0]        g2;
    logic [7:0]        b2;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wren;
    logic              busy;
    logic              frame_done;
    logic              frame_error;
    logic [CNT_W-1:0]  line_count;

    // Camera/host side: drives requests, sync and pixel pairs; observes writes and status.
    modport master (
        output capture_req, continuous, vsync, href, data_valid,
        output r1, g1, b1, r2, g2, b2,
        input  wr_addr, wr_data, wren, busy, frame_done, frame_error, line_count
    );

    // Capture controller side.
    modport slave (
        input  capture_req, continuous, vsync, href, data_valid,
        input  r1, g1, b1, r2, g2, b2,
        output wr_addr, wr_data, wren, busy, frame_done, frame_error, line_count
    );
endinterface

// File: rtl/cam_frame_capture_ctrl.sv
// Captures one vsync-aligned camera frame into an RGB332 frame buffer, pixel pairs written serially.
// Latency: pixel 1 written 1 cycle after data_valid, pixel 2 written 2 cycles after.
// Backpressure: none; pairs arriving while a write is pending or past the line end are dropped and flagged.
module cam_frame_capture_ctrl #(
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 480,
    parameter int ADDR_W   = 19,
    parameter int CNT_W    = 11
) (
    input logic                    pclk,
    input logic                    reset_n,
    cam_frame_capture_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        SYNC    = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]  H_CNT  = CNT_W'(H_PIXELS);
    localparam logic [CNT_W-1:0]  V_CNT  = CNT_W'(V_LINES);
    localparam logic [ADDR_W-1:0] H_ADDR = ADDR_W'(H_PIXELS);

    state_t            state;
    state_t            state_next;
    logic              last_vsync;
    logic              last_href;
    logic [CNT_W-1:0]  pix_cnt;
    logic [CNT_W-1:0]  line_count;
    logic [ADDR_W-1:0] line_base;
    logic              pending;
    logic [7:0]        pend_dat;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wren;
    logic              frame_error;
    logic              busy;
    logic              frame_done;

    logic              vsync_rise;
    logic              vsync_fall;
    logic              href_fall;
    logic              in_cap;
    logic              dv;
    logic              hf;
    logic              accept;
    logic              single;
    logic              dv_err;
    logic              hf_err;
    logic              vs_short;
    logic [CNT_W-1:0]  line_inc;
    logic [7:0]        pix1;
    logic [7:0]        pix2;
    logic              unused_bits;

    // RGB332 truncation keeps only the top bits of each colour channel.
    assign pix1 = {bus.r1[7:5], bus.g1[7:5], bus.b1[7:6]};
    assign pix2 = {bus.r2[7:5], bus.g2[7:5], bus.b2[7:6]};
    assign unused_bits = ^{bus.r1[4:0], bus.g1[4:0], bus.b1[5:0],
                           bus.r2[4:0], bus.g2[4:0], bus.b2[5:0]};

    assign vsync_rise = bus.vsync & ~last_vsync;
    assign vsync_fall = ~bus.vsync & last_vsync;
    assign href_fall  = ~bus.href & last_href;

    // href and data_valid only have meaning while a frame is being captured.
    assign in_cap   = (state == CAPTURE);
    assign dv       = in_cap & bus.data_valid;
    assign hf       = in_cap & href_fall;
    assign accept   = dv & ~pending & (pix_cnt < H_CNT) & (line_count < V_CNT);
    assign single   = accept & (pix_cnt == H_CNT - CNT_W'(1));
    assign dv_err   = (dv & ~accept) | single;
    assign hf_err   = hf & (pix_cnt != H_CNT);
    assign vs_short = in_cap & vsync_rise & (line_count < V_CNT);
    assign line_inc = line_count + CNT_W'(1);

    // State register.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state decode plus the state-derived busy and frame_done outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (bus.capture_req) state_next = ARMED;
            end
            ARMED: begin
                busy = 1'b1;
                // Waiting for a rising vsync guarantees we never join a frame midway.
                if (vsync_rise) state_next = SYNC;
            end
            SYNC: begin
                busy = 1'b1;
                if (vsync_fall) state_next = CAPTURE;
            end
            CAPTURE: begin
                busy = 1'b1;
                if (vs_short)                       state_next = DONE;
                else if (hf && (line_inc == V_CNT)) state_next = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_next = bus.continuous ? ARMED : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Sync edge history for the registered edge detectors.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            last_vsync <= 1'b0;
            last_href  <= 1'b0;
        end else begin
            last_vsync <= bus.vsync;
            last_href  <= bus.href;
        end
    end

    // Pixel/line position; a line end overrides any pixel advance in the same cycle.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            pix_cnt    <= '0;
            line_count <= '0;
            line_base  <= '0;
        end else if ((state == SYNC) && vsync_fall) begin
            pix_cnt    <= '0;
            line_count <= '0;
            line_base  <= '0;
        end else if (in_cap) begin
            if (accept) pix_cnt <= pix_cnt + CNT_W'(2);
            if (hf) begin
                pix_cnt    <= '0;
                line_count <= line_inc;
                line_base  <= line_base + H_ADDR;
            end
        end
    end

    // Write port: pixel 1 goes out immediately, pixel 2 is parked one cycle and written to the next address.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            wren     <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            pending  <= 1'b0;
            pend_dat <= '0;
        end else begin
            wren <= 1'b0;
            if (accept) begin
                wren    <= 1'b1;
                wr_data <= pix1;
                wr_addr <= line_base + ADDR_W'(pix_cnt);
                if (!single) begin
                    pending  <= 1'b1;
                    pend_dat <= pix2;
                end
            end else if (pending) begin
                // Completes at its original address even across a line end or into DONE.
                wren    <= 1'b1;
                wr_data <= pend_dat;
                wr_addr <= wr_addr + ADDR_W'(1);
                pending <= 1'b0;
            end
        end
    end

    // Sticky framing error, cleared each time the controller arms for a new frame.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            frame_error <= 1'b0;
        end else if ((state_next == ARMED) && (state != ARMED)) begin
            frame_error <= 1'b0;
        end else if (dv_err || hf_err || vs_short) begin
            frame_error <= 1'b1;
        end
    end

    assign bus.wr_addr     = wr_addr;
    assign bus.wr_data     = wr_data;
    assign bus.wren        = wren;
    assign bus.busy        = busy;
    assign bus.frame_done  = frame_done;
    assign bus.frame_error = frame_error;
    assign bus.line_count  = line_count;
endmodule

// File: tb/tb_cam_frame_capture_ctrl.sv
// Directed frame sequences with random pixel data against a line/strobe arithmetic model of the buffer.
// Latency: writes collected on the falling clock edge and compared in order per frame.
// Backpressure: none; the bench plays the camera and the buffer.
module tb_cam_frame_capture_ctrl;
    localparam int H = 4;
    localparam int V = 2;

    logic pclk;
    logic reset_n;

    cam_frame_capture_ctrl_if #(.ADDR_W(19), .CNT_W(11)) bus ();

    cam_frame_capture_ctrl #(
        .H_PIXELS(H),
        .V_LINES (V),
        .ADDR_W  (19),
        .CNT_W   (11)
    ) dut (
        .pclk   (pclk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic last_done_err = 1'b0;
    int exp_addr[$];
    int exp_dat[$];
    int obs_addr[$];
    int obs_dat[$];

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Buffer-side monitor, sampled mid-cycle.
    always @(negedge pclk) begin
        if (bus.wren === 1'b1) begin
            obs_addr.push_back(int'(bus.wr_addr));
            obs_dat.push_back(int'(bus.wr_data));
        end
        if (bus.frame_done === 1'b1) begin
            done_cnt++;
            last_done_err = bus.frame_error;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // RGB332 value of a pixel from its 8-bit channels.
    function automatic int rgb332(input int r, input int g, input int b);
        return (r / 32) * 32 + (g / 32) * 4 + (b / 64);
    endfunction

    task automatic compare_writes(input string tag);
        int n;
        check({tag, "_count"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
        n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(obs_addr[i]), 32'(exp_addr[i]));
            check($sformatf("%s_data%0d", tag, i), 32'(obs_dat[i]), 32'(exp_dat[i]));
        end
        obs_addr.delete(); obs_dat.delete();
        exp_addr.delete(); exp_dat.delete();
    endtask

    // One data_valid strobe; when live, the model places the pair at line*H + 2k, clipped at the line end.
    task automatic strobe(input int line, input int k, input bit fixed, input bit live);
        int v[6];
        int p;
        if (fixed) begin
            v[0] = 255; v[1] = 0; v[2] = 0; v[3] = 0; v[4] = 255; v[5] = 192;
        end else begin
            for (int i = 0; i < 6; i++) v[i] = int'($urandom_range(0, 255));
        end
        bus.r1 = 8'(v[0]); bus.g1 = 8'(v[1]); bus.b1 = 8'(v[2]);
        bus.r2 = 8'(v[3]); bus.g2 = 8'(v[4]); bus.b2 = 8'(v[5]);
        bus.data_valid = 1'b1;
        tick(1);
        bus.data_valid = 1'b0;
        if (live) begin
            p = 2 * k;
            if (p < H) begin
                exp_addr.push_back(line * H + p);
                exp_dat.push_back(rgb332(v[0], v[1], v[2]));
            end
            if (p + 1 < H) begin
                exp_addr.push_back(line * H + p + 1);
                exp_dat.push_back(rgb332(v[3], v[4], v[5]));
            end
        end
        tick(3);
    endtask

    task automatic send_line(input int line, input int n, input bit fixed, input bit live);
        bus.href = 1'b1;
        tick(2);
        for (int k = 0; k < n; k++) strobe(line, k, fixed, live);
        bus.href = 1'b0;
        tick(3);
    endtask

    task automatic vsync_pulse();
        bus.vsync = 1'b1;
        tick(4);
        bus.vsync = 1'b0;
        tick(3);
    endtask

    task automatic arm();
        bus.capture_req = 1'b1;
        tick(2);
        bus.capture_req = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        bus.capture_req = 1'b0; bus.continuous = 1'b0;
        bus.vsync = 1'b0; bus.href = 1'b0; bus.data_valid = 1'b0;
        bus.r1 = '0; bus.g1 = '0; bus.b1 = '0;
        bus.r2 = '0; bus.g2 = '0; bus.b2 = '0;
        tick(3);
        check("rst_wren", 32'(bus.wren), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.frame_done), 32'd0);
        check("rst_err", 32'(bus.frame_error), 32'd0);
        check("rst_lines", 32'(bus.line_count), 32'd0);
        check("rst_addr", 32'(bus.wr_addr), 32'd0);
        check("rst_data", 32'(bus.wr_data), 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Frame 1: strobes before vsync falls are ignored, then a clean 2x2-strobe frame.
        arm();
        check("armed_busy", 32'(bus.busy), 32'd1);
        bus.href = 1'b1;
        strobe(0, 0, 1'b0, 1'b0);
        strobe(0, 1, 1'b0, 1'b0);
        bus.vsync = 1'b1;
        tick(1);
        strobe(0, 0, 1'b0, 1'b0);
        check("sync_busy", 32'(bus.busy), 32'd1);
        bus.href = 1'b0;
        tick(2);
        compare_writes("pre_sync");
        bus.vsync = 1'b0;
        tick(3);
        send_line(0, 2, 1'b1, 1'b1);
        send_line(1, 2, 1'b1, 1'b1);
        check("f1_done", 32'(done_cnt), 32'd1);
        check("f1_err", 32'(bus.frame_error), 32'd0);
        check("f1_busy", 32'(bus.busy), 32'd0);
        check("f1_lines", 32'(bus.line_count), 32'd2);
        check("f1_hold_addr", 32'(bus.wr_addr), 32'(exp_addr[$]));
        check("f1_hold_data", 32'(bus.wr_data), 32'(exp_dat[$]));
        compare_writes("f1");

        // Short line then an overrunning line: second line still starts at H.
        arm();
        vsync_pulse();
        send_line(0, 1, 1'b0, 1'b1);
        send_line(1, 3, 1'b0, 1'b1);
        check("f2_done", 32'(done_cnt), 32'd2);
        check("f2_err", 32'(bus.frame_error), 32'd1);
        check("f2_lines", 32'(bus.line_count), 32'd2);
        check("f2_busy", 32'(bus.busy), 32'd0);
        compare_writes("f2");

        // Short frame: vsync rises after one line.
        arm();
        vsync_pulse();
        send_line(0, 2, 1'b0, 1'b1);
        bus.vsync = 1'b1;
        tick(3);
        check("f3_done", 32'(done_cnt), 32'd3);
        check("f3_err", 32'(bus.frame_error), 32'd1);
        check("f3_lines", 32'(bus.line_count), 32'd1);
        check("f3_busy", 32'(bus.busy), 32'd0);
        compare_writes("f3");
        bus.vsync = 1'b0;
        tick(2);

        // Continuous mode: three frames, the first with a short line.
        bus.continuous = 1'b1;
        arm();
        check("cont_arm_err", 32'(bus.frame_error), 32'd0);
        for (int f = 0; f < 3; f++) begin
            vsync_pulse();
            send_line(0, (f == 0) ? 1 : 2, 1'b0, 1'b1);
            if (f == 2) bus.continuous = 1'b0;
            send_line(1, 2, 1'b0, 1'b1);
            check($sformatf("cont%0d_done", f), 32'(done_cnt), 32'(4 + f));
            check($sformatf("cont%0d_done_err", f), 32'(last_done_err), (f == 0) ? 32'd1 : 32'd0);
            check($sformatf("cont%0d_err", f), 32'(bus.frame_error), 32'd0);
            check($sformatf("cont%0d_busy", f), 32'(bus.busy), (f < 2) ? 32'd1 : 32'd0);
            compare_writes($sformatf("cont%0d", f));
        end

        // Reset landing on the second-pixel write cycle.
        arm();
        vsync_pulse();
        bus.href = 1'b1;
        tick(2);
        bus.r1 = 8'($urandom_range(0, 255)); bus.g1 = 8'($urandom_range(0, 255));
        bus.b1 = 8'($urandom_range(0, 255));
        bus.r2 = 8'($urandom_range(0, 255)); bus.g2 = 8'($urandom_range(0, 255));
        bus.b2 = 8'($urandom_range(0, 255));
        exp_addr.push_back(0);
        exp_dat.push_back(rgb332(int'(bus.r1), int'(bus.g1), int'(bus.b1)));
        bus.data_valid = 1'b1;
        tick(1);
        bus.data_valid = 1'b0;
        @(posedge pclk);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_wren", 32'(bus.wren), 32'd0);
        check("ar_busy", 32'(bus.busy), 32'd0);
        check("ar_err", 32'(bus.frame_error), 32'd0);
        check("ar_lines", 32'(bus.line_count), 32'd0);
        check("ar_addr", 32'(bus.wr_addr), 32'd0);
        check("ar_data", 32'(bus.wr_data), 32'd0);
        bus.href = 1'b0;
        tick(2);
        compare_writes("ar_cut");
        reset_n = 1'b1;
        tick(1);
        bus.href = 1'b1;
        strobe(0, 0, 1'b0, 1'b0);
        arm();
        strobe(0, 0, 1'b0, 1'b0);
        bus.vsync = 1'b1;
        tick(2);
        strobe(0, 0, 1'b0, 1'b0);
        bus.href = 1'b0;
        tick(2);
        compare_writes("ar_quiet");
        bus.vsync = 1'b0;
        tick(3);
        send_line(0, 2, 1'b0, 1'b1);
        send_line(1, 2, 1'b0, 1'b1);
        check("ar_done", 32'(done_cnt), 32'd7);
        check("ar_frame_err", 32'(bus.frame_error), 32'd0);
        compare_writes("ar_frame");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
